// File: rtl/dff_grant_sequencer.sv
// -----------------------------------------------------------------------------
// dff_grant_sequencer
//
// Two requesters share one WIDTH-bit capture register. The block arbitrates
// round-robin between them and pulses a one-cycle grant. It loads the winner's
// data into q. It then holds q valid for HOLD_CYCLES cycles before it
// arbitrates again.
//
// Ports
//   clk        in   single clock; all state changes on the rising edge
//   rst_n      in   synchronous active-low reset; overrides ena
//   ena        in   tile enable; low freezes every register
//   req[1:0]   in   level request per requester
//   d0, d1     in   WIDTH-bit data of requester 0 / 1
//   gnt[1:0]   out  registered one-hot grant pulse (one cycle), else 0
//   q          out  capture register
//   q_valid    out  high while q is held for its owner
//   owner      out  index of the requester whose data sits in q
//   busy       out  high in any state other than IDLE
//   q_par      out  even parity of q when DFF_SEQ_PARITY_EN is defined, else 0
//   state_dbg  out  current FSM state (IDLE=0, GRANT=1, HOLD=2) for checkers
//
// Handshake: req is a level and has no ready or acknowledge other than gnt.
// At an edge in IDLE, a nonzero req commits a grant. After that the capture
// always completes, even if req drops. A requester that keeps req high
// arbitrates again once the block returns to IDLE.
//
// Optional feature macro: DFF_SEQ_PARITY_EN builds the parity register.
// -----------------------------------------------------------------------------
module dff_grant_sequencer #(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic [1:0]       gnt,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             owner,
  output logic             busy,
  output logic             q_par,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [7:0]       cnt, cnt_n;
  logic             last, last_n;
  logic [1:0]       gnt_n;
  logic [WIDTH-1:0] q_n;
  logic             q_valid_n;
  logic             owner_n;
  logic             win;
  logic [WIDTH-1:0] d_win;

  // During GRANT, last already holds the winner, so it selects the capture data.
  assign d_win = last ? d1 : d0;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    last_n    = last;
    gnt_n     = gnt;
    q_n       = q;
    q_valid_n = q_valid;
    owner_n   = owner;
    win       = 1'b0;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          // On a tie, the requester that did not win last time goes first.
          win     = (req == 2'b11) ? ~last : req[1];
          state_n = GRANT;
          gnt_n   = win ? 2'b10 : 2'b01;
          last_n  = win;
        end
      end
      GRANT: begin
        state_n   = HOLD;
        q_n       = d_win;
        owner_n   = last;
        q_valid_n = 1'b1;
        cnt_n     = 8'(HOLD_CYCLES - 1);
        gnt_n     = 2'b00;
      end
      HOLD: begin
        if (cnt != 8'd0) begin
          cnt_n = cnt - 8'd1;
        end else begin
          state_n   = IDLE;
          q_valid_n = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      last    <= 1'b1;
      gnt     <= 2'b00;
      q       <= '0;
      q_valid <= 1'b0;
      owner   <= 1'b0;
    end else if (ena) begin
      state   <= state_n;
      cnt     <= cnt_n;
      last    <= last_n;
      gnt     <= gnt_n;
      q       <= q_n;
      q_valid <= q_valid_n;
      owner   <= owner_n;
    end
  end

`ifdef DFF_SEQ_PARITY_EN
  logic q_par_r;
  // This register loads on the same edge as q, so it always equals ^q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_par_r <= 1'b0;
    end else if (ena && state == GRANT) begin
      q_par_r <= ^d_win;
    end
  end
  assign q_par = q_par_r;
`else
  assign q_par = 1'b0;
`endif

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule
